// File: rtl/pipe_stage_latch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pipe_stage_latch: generic valid/ready pipeline register stage with    |
// | optional 2-entry skid buffer, flush/NOP injection, perf counters.     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module pipe_stage_latch #(
  parameter int               WIDTH     = 64,
  parameter int               SKID      = 1,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}},
  parameter int               CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] bubble_count
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_EMPTY;
      main_q   <= NOP_VALUE;
      skid_q   <= NOP_VALUE;
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      state_q  <= state_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  // Next-state logic. With SKID=0, in_ready forces in_fire in ONE to
  // coincide with out_fire, so the TWO branch is never reached.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = ST_TWO;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            main_d  = NOP_VALUE;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end
  end

  // Saturating counters sample the pre-edge out_valid, so flush cycles count.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end
    if (!out_valid && out_ready && (bubble_q != CNT_MAX)) begin
      bubble_d = bubble_q + CNT_ONE;
    end
  end

  // Output decode
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    out_data  = main_q;
    case (state_q)
      ST_ONE:  occupancy = 2'd1;
      ST_TWO:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign stall_count  = stall_q;
  assign bubble_count = bubble_q;

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;
      logic in_ready_d;

      // Registered ready breaks any combinational path from out_ready.
      always_comb begin
        in_ready_d = (state_d != ST_TWO);
      end

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= in_ready_d;
        end
      end

      assign in_ready = in_ready_q;
    end else begin : g_no_skid
      assign in_ready = (state_q == ST_EMPTY) | out_ready;
    end
  endgenerate

endmodule
`default_nettype wire
